// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/load sequencer for a chain of external BCD digit counters
//
// Purpose:
//   Drives a cascade of DIGITS external BCD counters. It sequences count
//   enables on each tick and detects terminal count. It presets the counters
//   one digit per cycle over a shared 4-bit number bus.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tick         count-rate strobe (one cycle, spaced >= 2 cycles apart)
//   start_stop   pulse, toggles run / pause
//   clear        pulse, preset counters to all zeros
//   load         pulse, preset counters to load_value
//   load_value   BCD preset, nibble i is digit i
//   mode         count direction sampled at run start, 1 = up
//   digits       readback of counter values, nibble i is digit i
//   cnt_enable   per-digit count enable (one cycle after a tick)
//   cnt_up_down  latched count direction, 1 = up
//   cnt_set      per-digit set strobe, at most one bit high
//   bus_out      nibble driven onto the number bus
//   bus_oe       number bus drive enable
//   running      high while counting
//   busy         high while presetting
//   done         one-cycle pulse on terminal count

module stopwatch_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     cnt_enable,
  output logic                  cnt_up_down,
  output logic [DIGITS-1:0]     cnt_set,
  output logic [3:0]            bus_out,
  output logic                  bus_oe,
  output logic                  running,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state;

  // Operand nibbles not yet driven; shifted down one digit per LOAD cycle so
  // the next digit to drive is always in the low nibble.
  logic [4*DIGITS-1:0] operand;

  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] load_src;
  logic [DIGITS-1:0]   cascade;
  logic                all_nine;
  logic                all_zero;
  logic                terminal;
  logic                idle_like;
  logic                enter_load;
  logic                start_run;
  logic                pause_run;
  logic                count_tick;

  // Clamp each preset nibble to a legal BCD digit.
  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // Clear wins over load, so a clear always presets zeros.
  assign load_src = clear ? '0 : clamped;

  // Ripple-carry style enable cascade: digit i counts only when every lower
  // digit is at its wrap value for the latched direction.
  always_comb begin
    cascade  = '0;
    all_nine = 1'b1;
    all_zero = 1'b1;
    cascade[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      cascade[i] = cascade[i-1] &
                   (cnt_up_down ? (digits[4*(i-1) +: 4] == 4'd9)
                                : (digits[4*(i-1) +: 4] == 4'd0));
    end
    for (int i = 0; i < DIGITS; i++) begin
      all_nine = all_nine & (digits[4*i +: 4] == 4'd9);
      all_zero = all_zero & (digits[4*i +: 4] == 4'd0);
    end
  end

  assign terminal = cnt_up_down ? all_nine : all_zero;

  // Event decode with priority clear > start_stop > load. LOAD is absent from
  // every term, so all events are ignored while presetting.
  assign idle_like  = (state == S_IDLE) || (state == S_PAUSE) || (state == S_DONE);
  assign enter_load = (clear && (idle_like || state == S_RUN)) ||
                      (idle_like && load && !start_stop);
  assign start_run  = idle_like && !clear && start_stop;
  assign pause_run  = (state == S_RUN) && !clear && start_stop;
  // A tick coinciding with start_stop is dropped because pause wins.
  assign count_tick = (state == S_RUN) && !clear && !start_stop && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      operand     <= '0;
      cnt_enable  <= '0;
      cnt_up_down <= 1'b0;
      cnt_set     <= '0;
      bus_out     <= 4'd0;
      bus_oe      <= 1'b0;
      running     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Enables and done are single-cycle strobes.
      cnt_enable <= '0;
      done       <= 1'b0;

      if (enter_load) begin
        // Digit 0 goes out on the first LOAD cycle directly from the source;
        // the remaining digits are latched for the following cycles.
        state   <= S_LOAD;
        operand <= load_src >> 4;
        cnt_set <= DIGITS'(1);
        bus_out <= load_src[3:0];
        bus_oe  <= 1'b1;
        busy    <= 1'b1;
        running <= 1'b0;
      end else if (start_run) begin
        state       <= S_RUN;
        cnt_up_down <= mode;
        running     <= 1'b1;
      end else if (pause_run) begin
        state   <= S_PAUSE;
        running <= 1'b0;
      end else if (count_tick) begin
        if (terminal) begin
          state   <= S_DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt_enable <= cascade;
        end
      end else if (state == S_LOAD) begin
        if (cnt_set[DIGITS-1]) begin
          // Last digit has been set; release the bus.
          state   <= S_IDLE;
          cnt_set <= '0;
          bus_out <= 4'd0;
          bus_oe  <= 1'b0;
          busy    <= 1'b0;
        end else begin
          cnt_set <= cnt_set << 1;
          bus_out <= operand[3:0];
          operand <= operand >> 4;
        end
      end else if (!idle_like && state != S_RUN) begin
        // Unreachable encodings recover to IDLE.
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed table-driven bench for stopwatch_ctrl

module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          start_stop = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_value = '0;
  logic          mode = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    cnt_enable;
  logic          cnt_up_down;
  logic [3:0]    cnt_set;
  logic [3:0]    bus_out;
  logic          bus_oe;
  logic          running;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .load(load), .load_value(load_value), .mode(mode), .digits(digits),
    .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down), .cnt_set(cnt_set),
    .bus_out(bus_out), .bus_oe(bus_oe), .running(running), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output record: {en, up_down, set, bus, oe, running, busy, done}
  function automatic logic [16:0] pk(input logic [3:0] en, input logic ud, input logic [3:0] set,
                                     input logic [3:0] bus, input logic oe, input logic run,
                                     input logic bsy, input logic dn);
    return {en, ud, set, bus, oe, run, bsy, dn};
  endfunction

  logic [16:0] act_o;
  assign act_o = {cnt_enable, cnt_up_down, cnt_set, bus_out, bus_oe, running, busy, done};

  typedef struct {
    string       name;
    logic        r, t, s, c, l;
    logic [15:0] lv;
    logic        m;
    logic [15:0] dg;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic t, input logic s, input logic c,
                     input logic l, input logic [15:0] lv, input logic m, input logic [15:0] dg,
                     input logic [16:0] e);
    vec_t v;
    v.name = nm; v.r = r; v.t = t; v.s = s; v.c = c; v.l = l;
    v.lv = lv; v.m = m; v.dg = dg; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rst = 0; tick = 0; start_stop = 0; clear = 0; load = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants checked every cycle once out of reset.
  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("oe_matches_set", {31'd0, bus_oe}, {31'd0, (cnt_set != 4'd0)});
      chk("set_onehot0", {31'd0, $onehot0(cnt_set)}, 32'd1);
    end
  end

  int          n;
  int          dcnt;
  int          ecnt;
  logic [3:0]  got [4];
  logic [3:0]  first_en;

  initial begin
    //   name            rst t ss clr ld  lv        m  digits     expected {en,ud,set,bus,oe,run,busy,done}
    add("reset",          1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("idle",           0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("ld0305_d0",      0, 0, 0, 0, 1, 16'h0305, 0, 16'h0000, pk(4'h0,0,4'h1,4'h5,1,0,1,0));
    add("ld0305_d1",      0, 0, 0, 0, 0, 16'hFFFF, 0, 16'h0000, pk(4'h0,0,4'h2,4'h0,1,0,1,0));
    add("ld0305_d2_clr",  0, 0, 0, 1, 0, 16'hFFFF, 0, 16'h0000, pk(4'h0,0,4'h4,4'h3,1,0,1,0));
    add("ld0305_d3_ss",   0, 0, 1, 0, 0, 16'hFFFF, 0, 16'h0000, pk(4'h0,0,4'h8,4'h0,1,0,1,0));
    add("ld0305_end",     0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("ld00A2_d0",      0, 0, 0, 0, 1, 16'h00A2, 0, 16'h0000, pk(4'h0,0,4'h1,4'h2,1,0,1,0));
    add("ld00A2_d1",      0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h2,4'h9,1,0,1,0));
    add("ld00A2_d2",      0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h4,4'h0,1,0,1,0));
    add("ld00A2_d3",      0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h8,4'h0,1,0,1,0));
    add("ld00A2_end",     0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("run_up",         0, 0, 1, 0, 0, 16'h0000, 1, 16'h0099, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("tick_0099",      0, 1, 0, 0, 0, 16'h0000, 0, 16'h0099, pk(4'h7,1,4'h0,4'h0,0,1,0,0));
    add("en_one_cycle",   0, 0, 0, 0, 0, 16'h0000, 0, 16'h0100, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("tick_0100_up",   0, 1, 0, 0, 0, 16'h0000, 0, 16'h0100, pk(4'h1,1,4'h0,4'h0,0,1,0,0));
    add("run_gap",        0, 0, 0, 0, 0, 16'h0000, 0, 16'h0101, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("ld_in_run",      0, 0, 0, 0, 1, 16'h1234, 0, 16'h1239, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("tick_1239",      0, 1, 0, 0, 0, 16'h0000, 0, 16'h1239, pk(4'h3,1,4'h0,4'h0,0,1,0,0));
    add("run_gap2",       0, 0, 0, 0, 0, 16'h0000, 0, 16'h1240, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("tick_with_ss",   0, 1, 1, 0, 0, 16'h0000, 0, 16'h0009, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("pause_hold",     0, 0, 0, 0, 0, 16'h0000, 0, 16'h0009, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("pause_tick",     0, 1, 0, 0, 0, 16'h0000, 0, 16'h0009, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("run_down",       0, 0, 1, 0, 0, 16'h0000, 0, 16'h0100, pk(4'h0,0,4'h0,4'h0,0,1,0,0));
    add("tick_0100_dn",   0, 1, 0, 0, 0, 16'h0000, 0, 16'h0100, pk(4'h7,0,4'h0,4'h0,0,1,0,0));
    add("run_gap3",       0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,1,0,0));
    add("tick_dn_term",   0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,1));
    add("done_pulse_end", 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("run_up2",        0, 0, 1, 0, 0, 16'h0000, 1, 16'h9999, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("tick_up_term",   0, 1, 0, 0, 0, 16'h0000, 0, 16'h9999, pk(4'h0,1,4'h0,4'h0,0,0,0,1));
    add("done_hold",      0, 0, 0, 0, 0, 16'h0000, 0, 16'h9999, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("run_again",      0, 0, 1, 0, 0, 16'h0000, 1, 16'h0000, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("clr_ss_run_d0",  0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h1,4'h0,1,0,1,0));
    add("clr_ss_run_d1",  0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h2,4'h0,1,0,1,0));
    add("clr_ss_run_d2",  0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h4,4'h0,1,0,1,0));
    add("clr_ss_run_d3",  0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h8,4'h0,1,0,1,0));
    add("clr_ss_run_end", 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("clr_ld_idle_d0", 0, 0, 0, 1, 1, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h1,4'h0,1,0,1,0));
    add("clr_ld_idle_d1", 0, 0, 0, 0, 0, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h2,4'h0,1,0,1,0));
    add("clr_ld_idle_d2", 0, 0, 0, 0, 0, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h4,4'h0,1,0,1,0));
    add("clr_ld_idle_d3", 0, 0, 0, 0, 0, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h8,4'h0,1,0,1,0));
    add("clr_ld_idle_end",0, 0, 0, 0, 0, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("ss_ld_idle",     0, 0, 1, 0, 1, 16'h0305, 1, 16'h0000, pk(4'h0,1,4'h0,4'h0,0,1,0,0));
    add("ss_pause",       0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h0,4'h0,0,0,0,0));
    add("ld_pause_d0",    0, 0, 0, 0, 1, 16'h0305, 0, 16'h0000, pk(4'h0,1,4'h1,4'h5,1,0,1,0));
    add("ld_pause_d1",    0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,1,4'h2,4'h0,1,0,1,0));
    add("rst_mid_load",   1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));
    add("after_rst",      0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, pk(4'h0,0,4'h0,4'h0,0,0,0,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r; tick = vecs[i].t; start_stop = vecs[i].s; clear = vecs[i].c;
      load = vecs[i].l; load_value = vecs[i].lv; mode = vecs[i].m; digits = vecs[i].dg;
      step();
      chk(vecs[i].name, {15'd0, act_o}, {15'd0, vecs[i].exp});
      armed = 1'b1;
    end
    idle_inputs();

    // Preset 0x9876: busy for exactly four cycles, digits leave low first.
    load_value = 16'h9876;
    load = 1;
    step();
    load = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin
        if (n < 4) got[n] = bus_out;
        n++;
      end else if (n > 0) begin
        break;
      end
      step();
    end
    chk("busy_cycles", n, 4);
    chk("seq_bus_d0", {28'd0, got[0]}, 32'd6);
    chk("seq_bus_d1", {28'd0, got[1]}, 32'd7);
    chk("seq_bus_d2", {28'd0, got[2]}, 32'd8);
    chk("seq_bus_d3", {28'd0, got[3]}, 32'd9);

    // Down count from zero: done pulses exactly once.
    mode = 0; digits = 16'h0000;
    start_stop = 1;
    step();
    start_stop = 0;
    chk("seq_running", {31'd0, running}, 32'd1);
    tick = 1;
    step();
    tick = 0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dcnt++;
      step();
    end
    chk("seq_done_once", dcnt, 1);
    chk("seq_stopped", {31'd0, running}, 32'd0);

    // Up count from 0009 out of DONE: a single enable cycle of 0011.
    mode = 1; digits = 16'h0009;
    start_stop = 1;
    step();
    start_stop = 0;
    tick = 1;
    step();
    tick = 0;
    ecnt = 0;
    first_en = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_enable != 4'h0) begin
        if (ecnt == 0) first_en = cnt_enable;
        ecnt++;
      end
      step();
    end
    chk("seq_en_cycles", ecnt, 1);
    chk("seq_en_value", {28'd0, first_en}, 32'h3);

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of cascaded BCD digit counters; digit 0 is least significant.
REQ-002 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: tick  in  1  one-cycle count-rate strobe; consecutive ticks spaced ≥2 clk cycles.
REQ-005 Port: start_stop  in  1  one-cycle pulse; toggles run/pause.
REQ-006 Port: clear  in  1  one-cycle pulse; loads all-zero into the counters.
REQ-007 Port: load  in  1  one-cycle pulse; loads load_value into the counters.
REQ-008 Port: load_value  in  4*DIGITS  BCD preset; nibble i is digit i.
REQ-009 Port: mode  in  1  count direction, 1 = up, 0 = down; sampled on the run-start edge only.
REQ-010 Port: digits  in  4*DIGITS  readback of the counter values; nibble i is digit i.
REQ-011 Port: cnt_enable  out  DIGITS  per-digit count enable.
REQ-012 Port: cnt_up_down  out  1  direction to all counters, 1 = up.
REQ-013 Port: cnt_set  out  DIGITS  per-digit set strobe, at most one bit high.
REQ-014 Port: bus_out  out  4  value driven onto the shared half-duplex number bus.
REQ-015 Port: bus_oe  out  1  bus drive enable; bus is high-Z when low.
REQ-016 Port: running  out  1  high in RUN.
REQ-017 Port: busy  out  1  high in LOAD.
REQ-018 Port: done  out  1  one-cycle pulse on terminal count.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, PAUSE, LOAD and DONE; all outputs SHALL be registered.
REQ-020 Event priority in any state other than LOAD: clear > start_stop > load; lower-priority events in the same cycle are dropped.
REQ-021 clear or load in IDLE, PAUSE or DONE -> LOAD; load in RUN is ignored; clear in RUN stops counting -> LOAD with zeros.
REQ-022 LOAD SHALL drive one digit per cycle, digit 0 first, for DIGITS cycles: cnt_set one-hot at bit k, bus_oe=1, bus_out=nibble k, then -> IDLE.
REQ-023 The LOAD operand SHALL be latched on entry; any nibble >9 is clamped to 9.
REQ-024 All events are ignored during LOAD.
REQ-025 bus_oe SHALL be 1 only while a cnt_set bit is 1.
REQ-026 start_stop in IDLE, PAUSE or DONE -> RUN, latching cnt_up_down=mode; start_stop in RUN -> PAUSE.
REQ-027 In RUN, the cycle after a tick: cnt_enable[0]=1, and cnt_enable[i]=cnt_enable[i-1] AND (digits[i-1]==9 when up, ==0 when down); enables last exactly one cycle.
REQ-028 Terminal count: up with all digits 9, or down with all digits 0, at a tick -> no enables, done=1 for one cycle, -> DONE.
REQ-029 The up-mode cascade SHALL roll over 0099 -> 0100 (digits 0,1 enabled, digit 2 enabled, digit 3 not).
REQ-030 cnt_enable SHALL be 0 in every state except the post-tick cycle in RUN.
REQ-031 A tick coincident with start_stop in RUN is dropped (pause wins).

Reset
REQ-032 rst SHALL force IDLE with all outputs 0, including cnt_up_down and bus_oe; the latched operand is cleared.
REQ-033 rst mid-LOAD SHALL abort the sequence and release the bus on the next cycle; remaining digits are not set.

Verification
REQ-034 rst, then load with load_value=0x0305 -> 4 cycles: cnt_set 0001/0010/0100/1000, bus_out 5/0/3/0, bus_oe=1 each; then busy=0, state IDLE.
REQ-035 digits=0x0099, mode=1, start_stop, tick -> cnt_enable=0111 for one cycle, running=1.
REQ-036 digits=0x0000, mode=0, start_stop, tick -> cnt_enable=0000, done pulse, running=0.
REQ-037 RUN, clear and start_stop in the same cycle -> LOAD with zeros (bus_out=0 for 4 cycles), start_stop dropped.
REQ-038 load_value=0x00A2 -> bus_out sequence 2, 9, 0, 0.
REQ-039 rst asserted in the 2nd LOAD cycle -> next cycle cnt_set=0000, bus_oe=0, busy=0.
